// File: rtl/cpc_mem_pkg.sv
// Shared definitions for the CPC SRAM arbiter: address width, requester ids and FSM states.
package cpc_mem_pkg;

    localparam int AW = 21;

    typedef enum logic [1:0] {
        REQ_VID  = 2'd0,
        REQ_CPU  = 2'd1,
        REQ_HOST = 2'd2
    } req_id_e;

    typedef enum logic [1:0] {
        ST_ARB      = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_HOSTWAIT = 2'd2
    } state_e;

endpackage

// File: rtl/sram_access_timer.sv
// Counts the ACC_CYCLES phases of one SRAM access; the write strobe is registered and
// low for phases 1..ACC_CYCLES-1, last_o marks the edge on which read data is captured.
module sram_access_timer #(
    parameter int ACC_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic wr_i,
    output logic last_o,
    output logic we_n_o
);
    localparam int CW = $clog2(ACC_CYCLES);

    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          wr_q;
    logic          we_n_q;

    assign last_o = busy_q && (cnt_q == CW'(ACC_CYCLES - 1));
    assign we_n_o = we_n_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            wr_q   <= 1'b0;
            we_n_q <= 1'b1;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            wr_q   <= wr_i;
            we_n_q <= 1'b1;
        end else if (last_o) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            we_n_q <= 1'b1;
        end else if (busy_q) begin
            cnt_q  <= cnt_q + CW'(1);
            we_n_q <= ~wr_q;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the external byte SRAM between video fetch, CPU and host word writer (fixed
// priority, non-preemptive); request in ARB at T completes at T+ACC_CYCLES+1.
module sram_arbiter
    import cpc_mem_pkg::*;
#(
    parameter int ACC_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [7:0]    vid_data,
    output logic          vid_valid,
    output logic          vid_overrun,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_ack,
    input  logic          host_req,
    input  logic [AW-1:0] host_addr,
    input  logic [31:0]   host_data,
    output logic          host_ack,
    output logic [AW-1:0] sram_addr,
    output logic [7:0]    sram_dout,
    output logic          sram_dout_oe,
    input  logic [7:0]    sram_din,
    output logic          sram_we_n
);
    state_e        state_q;
    req_id_e       req_id_q;
    logic          req_we_q;
    logic          vid_pend_q, vid_overrun_q, vid_valid_q, cpu_ack_q, host_ack_q, oe_q;
    logic [AW-1:0] vid_addr_q, addr_q;
    logic [7:0]    vid_data_q, cpu_rdata_q, dout_q;
    logic [1:0]    host_idx_q;
    logic [AW-3:0] host_base_q, host_base_d;
    logic [31:0]   host_word_q, host_word_d;

    logic          arb_en, vid_want, cpu_want, host_want;
    logic          grant_vid, grant_cpu, grant_host, grant, grant_we, acc_last;
    logic [AW-1:0] grant_addr;
    logic [7:0]    grant_dout;
    logic          unused_host_lsb;

    // Host addresses are word aligned; the low two bits are don't-care.
    assign unused_host_lsb = ^host_addr[1:0];

    assign arb_en     = (state_q == ST_ARB) || (state_q == ST_HOSTWAIT);
    assign vid_want   = vid_pend_q || vid_req;
    assign cpu_want   = cpu_req && !cpu_ack_q;
    assign host_want  = (state_q == ST_ARB) && !host_ack_q && (host_req || host_idx_q != 2'd0);
    assign grant_vid  = arb_en && vid_want;
    assign grant_cpu  = arb_en && !vid_want && cpu_want;
    assign grant_host = arb_en && !vid_want && !cpu_want && host_want;
    assign grant      = grant_vid || grant_cpu || grant_host;
    assign grant_we   = grant_host || (grant_cpu && cpu_we);

    // The word is latched with byte 0 so a host dropping req mid-word cannot corrupt it.
    assign host_base_d = (host_idx_q == 2'd0) ? host_addr[AW-1:2] : host_base_q;
    assign host_word_d = (host_idx_q == 2'd0) ? host_data : host_word_q;

    always_comb begin
        grant_addr = {host_base_d, host_idx_q};
        grant_dout = host_word_d[{host_idx_q, 3'b000} +: 8];
        if (grant_vid) begin
            grant_addr = vid_pend_q ? vid_addr_q : vid_addr;
            grant_dout = 8'h00;
        end else if (grant_cpu) begin
            grant_addr = cpu_addr;
            grant_dout = cpu_wdata;
        end
    end

    sram_access_timer #(
        .ACC_CYCLES(ACC_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .start_i(grant),
        .wr_i   (grant_we),
        .last_o (acc_last),
        .we_n_o (sram_we_n)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_ARB;
            req_id_q      <= REQ_VID;
            req_we_q      <= 1'b0;
            vid_pend_q    <= 1'b0;
            vid_overrun_q <= 1'b0;
            vid_valid_q   <= 1'b0;
            cpu_ack_q     <= 1'b0;
            host_ack_q    <= 1'b0;
            oe_q          <= 1'b0;
            vid_addr_q    <= '0;
            addr_q        <= '0;
            vid_data_q    <= 8'h00;
            cpu_rdata_q   <= 8'h00;
            dout_q        <= 8'h00;
            host_idx_q    <= 2'd0;
            host_base_q   <= '0;
            host_word_q   <= 32'h0;
        end else begin
            vid_valid_q <= 1'b0;
            cpu_ack_q   <= 1'b0;
            vid_pend_q  <= (vid_pend_q && !grant_vid) || (vid_req && (vid_pend_q || !grant_vid));
            if (vid_req) begin
                vid_addr_q <= vid_addr;
            end
            if (vid_req && vid_pend_q && !grant_vid) begin
                vid_overrun_q <= 1'b1;
            end
            if (host_ack_q && !host_req) begin
                host_ack_q <= 1'b0;
            end
            case (state_q)
                ST_ARB, ST_HOSTWAIT: begin
                    if (grant) begin
                        state_q  <= ST_ACCESS;
                        req_id_q <= grant_vid ? REQ_VID : (grant_cpu ? REQ_CPU : REQ_HOST);
                        req_we_q <= grant_we;
                        addr_q   <= grant_addr;
                        dout_q   <= grant_dout;
                        oe_q     <= grant_we;
                        if (grant_host) begin
                            host_base_q <= host_base_d;
                            host_word_q <= host_word_d;
                        end
                    end else if (state_q == ST_HOSTWAIT && !host_req) begin
                        state_q <= ST_ARB;
                    end
                end
                ST_ACCESS: begin
                    if (acc_last) begin
                        oe_q    <= 1'b0;
                        state_q <= (host_ack_q && host_req) ? ST_HOSTWAIT : ST_ARB;
                        case (req_id_q)
                            REQ_VID: begin
                                vid_data_q  <= sram_din;
                                vid_valid_q <= 1'b1;
                            end
                            REQ_CPU: begin
                                if (!req_we_q) begin
                                    cpu_rdata_q <= sram_din;
                                end
                                cpu_ack_q <= 1'b1;
                            end
                            default: begin
                                host_idx_q <= host_idx_q + 2'd1;
                                if (host_idx_q == 2'd3) begin
                                    host_ack_q <= 1'b1;
                                    state_q    <= ST_HOSTWAIT;
                                end
                            end
                        endcase
                    end
                end
                default: state_q <= ST_ARB;
            endcase
        end
    end

    assign vid_data     = vid_data_q;
    assign vid_valid    = vid_valid_q;
    assign vid_overrun  = vid_overrun_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign cpu_ack      = cpu_ack_q;
    assign host_ack     = host_ack_q;
    assign sram_addr    = addr_q;
    assign sram_dout    = dout_q;
    assign sram_dout_oe = oe_q;

endmodule
